// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of an asynchronous PWM input in
// prescaled ticks; one valid strobe per complete period, lost flags timeout.
module pwm_capture #(
  parameter int CTR_LEN = 16,
  parameter int DIV     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sig_in,
  output logic [CTR_LEN-1:0] high_cnt,
  output logic [CTR_LEN-1:0] period_cnt,
  output logic               valid,
  output logic               lost
);

  localparam int                 PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [CTR_LEN-1:0] CTR_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  logic               r_sync1;
  logic               r_sig_s;
  logic               r_sig_d;
  logic [PRE_W-1:0]   r_pre;
  logic [CTR_LEN-1:0] r_elapsed;
  logic [CTR_LEN-1:0] r_high_pend;
  state_t             r_state;

  logic               w_rise;
  logic               w_fall;
  logic               w_tick;
  logic               w_timeout;
  logic [PRE_W-1:0]   w_pre_base;
  logic [CTR_LEN-1:0] w_elapsed_base;

  assign w_rise = r_sig_s & ~r_sig_d;
  assign w_fall = ~r_sig_s & r_sig_d;

  // The rise cycle itself counts as the first cycle of the new interval, so
  // the value read at the next edge is floor(cycles/DIV) for the full interval.
  always_comb begin
    w_pre_base     = r_pre;
    w_elapsed_base = r_elapsed;
    if (w_rise) begin
      w_pre_base     = '0;
      w_elapsed_base = '0;
    end else begin
      w_pre_base     = r_pre;
      w_elapsed_base = r_elapsed;
    end
    w_tick    = (w_pre_base == PRE_LAST);
    w_timeout = (r_elapsed == CTR_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sig_s <= 1'b0;
      r_sig_d <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_sig_s <= r_sync1;
      r_sig_d <= r_sig_s;
    end
  end

  // Elapsed saturates so an idle input can never wrap back into a valid range.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre     <= '0;
      r_elapsed <= '0;
    end else begin
      if (w_tick) begin
        r_pre <= '0;
      end else begin
        r_pre <= w_pre_base + PRE_W'(1);
      end
      if (w_tick && (w_elapsed_base != CTR_MAX)) begin
        r_elapsed <= w_elapsed_base + CTR_LEN'(1);
      end else begin
        r_elapsed <= w_elapsed_base;
      end
    end
  end

  // Timeout takes priority over a coincident edge, capping the period at 2^N-2.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_high_pend <= '0;
      high_cnt    <= '0;
      period_cnt  <= '0;
      valid       <= 1'b0;
      lost        <= 1'b1;
    end else begin
      valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state <= S_HIGH;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_HIGH: begin
          if (w_timeout) begin
            r_state <= S_IDLE;
            lost    <= 1'b1;
          end else if (w_fall) begin
            r_high_pend <= r_elapsed;
            r_state     <= S_LOW;
          end else begin
            r_state <= S_HIGH;
          end
        end
        S_LOW: begin
          if (w_timeout) begin
            r_state <= S_IDLE;
            lost    <= 1'b1;
          end else if (w_rise) begin
            high_cnt   <= r_high_pend;
            period_cnt <= r_elapsed;
            valid      <= 1'b1;
            lost       <= 1'b0;
            r_state    <= S_HIGH;
          end else begin
            r_state <= S_LOW;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: three instances (DIV=1, DIV=4, CTR_LEN=8)
// exercised one at a time with hand-computed expected measurements.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        sig_a, sig_b, sig_c;
  logic [15:0] a_high, a_per, b_high, b_per;
  logic [7:0]  c_high, c_per;
  logic        a_valid, a_lost, b_valid, b_lost, c_valid, c_lost;

  always #5 clk = ~clk;

  pwm_capture #(.CTR_LEN(16), .DIV(1)) u_a (
    .clk(clk), .rst(rst), .sig_in(sig_a),
    .high_cnt(a_high), .period_cnt(a_per), .valid(a_valid), .lost(a_lost));

  pwm_capture #(.CTR_LEN(16), .DIV(4)) u_b (
    .clk(clk), .rst(rst), .sig_in(sig_b),
    .high_cnt(b_high), .period_cnt(b_per), .valid(b_valid), .lost(b_lost));

  pwm_capture #(.CTR_LEN(8), .DIV(1)) u_c (
    .clk(clk), .rst(rst), .sig_in(sig_c),
    .high_cnt(c_high), .period_cnt(c_per), .valid(c_valid), .lost(c_lost));

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          cur = 0;
  logic [31:0] o_high, o_per;
  logic        o_valid, o_lost;
  logic        prev_valid, prev_lost;
  int          vcount, consec, unexp, lost_rise_t, t0;
  int          vtimes[$];
  int          exp_hi[$];
  int          exp_per[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sample();
    case (cur)
      0: begin o_high = 32'(a_high); o_per = 32'(a_per); o_valid = a_valid; o_lost = a_lost; end
      1: begin o_high = 32'(b_high); o_per = 32'(b_per); o_valid = b_valid; o_lost = b_lost; end
      default: begin o_high = 32'(c_high); o_per = 32'(c_per); o_valid = c_valid; o_lost = c_lost; end
    endcase
  endtask

  task automatic select(input int which);
    cur    = which;
    vcount = 0;
    consec = 0;
    unexp  = 0;
    lost_rise_t = -1;
    vtimes.delete();
    exp_hi.delete();
    exp_per.delete();
    sample();
    prev_valid = o_valid;
    prev_lost  = o_lost;
  endtask

  // One clock; observe the selected DUT and score any valid strobe.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    sample();
    if (o_valid === 1'b1) begin
      if (prev_valid === 1'b1) consec++;
      vcount++;
      vtimes.push_back(cyc);
      if (exp_hi.size() > 0) begin
        check("high_cnt", o_high, exp_hi.pop_front());
        check("period_cnt", o_per, exp_per.pop_front());
        check("lost_at_valid", 32'(o_lost), 0);
      end else begin
        unexp++;
      end
    end
    if ((o_lost === 1'b1) && (prev_lost !== 1'b1)) lost_rise_t = cyc;
    prev_valid = o_valid;
    prev_lost  = o_lost;
  endtask

  task automatic drive(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      case (cur)
        0: sig_a = lvl;
        1: sig_b = lvl;
        default: sig_c = lvl;
      endcase
      tick();
    end
  endtask

  task automatic pwm(input int h, input int l, input int periods);
    repeat (periods) begin
      drive(1'b1, h);
      drive(1'b0, l);
    end
  endtask

  task automatic push(input int h, input int p, input int n);
    repeat (n) begin
      exp_hi.push_back(h);
      exp_per.push_back(p);
    end
  endtask

  task automatic finish_test(input string tag, input int exp_n);
    check({tag, "_valid_count"}, vcount, exp_n);
    check({tag, "_unexpected_valid"}, unexp, 0);
    check({tag, "_missing_valid"}, exp_hi.size(), 0);
    check({tag, "_back_to_back_valid"}, consec, 0);
  endtask

  initial begin
    rst = 1'b1; sig_a = 1'b0; sig_b = 1'b0; sig_c = 1'b0;
    select(0);
    repeat (3) tick();
    check("rst_a_high", 32'(a_high), 0);  check("rst_a_per", 32'(a_per), 0);
    check("rst_a_valid", 32'(a_valid), 0); check("rst_a_lost", 32'(a_lost), 1);
    check("rst_b_high", 32'(b_high), 0);  check("rst_b_per", 32'(b_per), 0);
    check("rst_b_valid", 32'(b_valid), 0); check("rst_b_lost", 32'(b_lost), 1);
    check("rst_c_high", 32'(c_high), 0);  check("rst_c_per", 32'(c_per), 0);
    check("rst_c_valid", 32'(c_valid), 0); check("rst_c_lost", 32'(c_lost), 1);
    rst = 1'b0;

    // DIV=1, 30/70: first period discarded, then 3 valids 100 cycles apart
    select(0);
    push(30, 100, 3);
    drive(1'b0, 5);
    pwm(30, 70, 1);
    check("A_no_early_valid", vcount, 0);
    check("A_lost_before_valid", 32'(o_lost), 1);
    t0 = cyc + 1;
    pwm(30, 70, 3);
    check("A_latency", vtimes[0], t0 + 2);
    check("A_spacing_1", vtimes[1] - vtimes[0], 100);
    check("A_spacing_2", vtimes[2] - vtimes[1], 100);
    check("A_lost_after", 32'(o_lost), 0);
    finish_test("A", 3);

    // DIV=4: 40/60 -> 10/25, then sub-tick 3/97 -> 0/25
    select(1);
    push(10, 25, 3);
    push(0, 25, 2);
    pwm(40, 60, 3);
    pwm(3, 97, 2);
    drive(1'b1, 3);
    drive(1'b0, 10);
    check("B_last_high", o_high, 0);
    check("B_last_per", o_per, 25);
    finish_test("B", 5);

    // DIV=1 minimum pulse 1/9, ending held high so the FSM sits in HIGH
    rst = 1'b1; tick(); rst = 1'b0;
    select(0);
    push(1, 10, 5);
    pwm(1, 9, 5);
    drive(1'b1, 10);
    finish_test("C", 5);
    for (int i = 0; i < 4; i++) check("C_spacing", vtimes[i + 1] - vtimes[i], 10);

    // Reset while the pulse is high
    rst = 1'b1; tick(); rst = 1'b0;
    check("E_rst_high", o_high, 0);
    check("E_rst_per", o_per, 0);
    check("E_rst_valid", 32'(o_valid), 0);
    check("E_rst_lost", 32'(o_lost), 1);
    select(0);
    push(25, 100, 2);
    drive(1'b0, 20);
    pwm(25, 75, 1);
    check("E_no_early_valid", vcount, 0);
    check("E_lost_before_valid", 32'(o_lost), 1);
    pwm(25, 75, 1);
    drive(1'b1, 5);
    check("E_lost_after", 32'(o_lost), 0);
    finish_test("E", 2);

    // CTR_LEN=8 timeout: lost 255 cycles after the last rise, outputs held
    select(2);
    push(10, 30, 2);
    pwm(10, 20, 3);
    check("D_valids_before_hold", vcount, 2);
    drive(1'b0, 300);
    check("D_timeout_delay", lost_rise_t - vtimes[1], 255);
    check("D_hold_high", o_high, 10);
    check("D_hold_per", o_per, 30);
    check("D_hold_lost", 32'(o_lost), 1);
    check("D_no_valid_in_hold", vcount, 2);
    push(10, 30, 2);
    pwm(10, 20, 3);
    check("D_lost_cleared", 32'(o_lost), 0);
    finish_test("D", 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
